// File: rtl/disp_write_arbiter_if.sv
// Requester A/B valid/ready pixel-write channels plus the registered display BRAM write port.
// master = requesters and BRAM side, slave = disp_write_arbiter.
interface disp_write_arbiter_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 24
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              write_en;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, addr, data, write_en
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, addr, data, write_en
  );
endinterface

// File: rtl/disp_write_arbiter.sv
// Round-robin owner of the display BRAM write port with an optional whole-frame fill sequencer.
// Fill sequencer is built only when DISP_WRITE_FILL_EN is defined.
module disp_write_arbiter #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DEPTH  = 8192
) (
  input  logic              clk_bram_disp,
  input  logic              rst,
  disp_write_arbiter_if.slave bus,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              last_grant
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              write_en_q, write_en_d;
  logic              last_grant_q, last_grant_d;
  logic              hold_c, a_win_c, b_win_c, a_hs_c, b_hs_c;

  // last_grant_q=1 means B went last, so A wins a tie
  assign a_win_c     = bus.a_valid & (~bus.b_valid | last_grant_q);
  assign b_win_c     = bus.b_valid & (~bus.a_valid | ~last_grant_q);
  assign bus.a_ready = a_win_c & ~hold_c;
  assign bus.b_ready = b_win_c & ~hold_c;
  assign a_hs_c      = bus.a_valid & bus.a_ready;
  assign b_hs_c      = bus.b_valid & bus.b_ready;

  assign bus.addr     = addr_q;
  assign bus.data     = data_q;
  assign bus.write_en = write_en_q;
  assign last_grant   = last_grant_q;

`ifdef DISP_WRITE_FILL_EN
  typedef enum logic {IDLE, FILL} state_e;
  localparam int unsigned      CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Fill owns the port from the cycle fill_start is seen until the last write
  assign hold_c    = (state_q == FILL) | fill_start;
  assign fill_busy = busy_q;
  assign fill_done = done_q;

  always_ff @(posedge clk_bram_disp or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      color_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
`else
  logic unused_fill_c;

  assign hold_c        = 1'b0;
  assign fill_busy     = 1'b0;
  assign fill_done     = 1'b0;
  assign unused_fill_c = ^{fill_start, fill_color};
`endif

  always_comb begin
    addr_d       = addr_q;
    data_d       = data_q;
    write_en_d   = 1'b0;
    last_grant_d = last_grant_q;
`ifdef DISP_WRITE_FILL_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    done_d  = 1'b0;
    if (state_q == FILL) begin
      addr_d     = cnt_q[ADDR_W-1:0];
      data_d     = color_q;
      write_en_d = 1'b1;
      if (cnt_q == LAST_CNT) begin
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (fill_start) begin
      color_d    = fill_color;
      addr_d     = '0;
      data_d     = fill_color;
      write_en_d = 1'b1;
      cnt_d      = CNT_W'(1);
      state_d    = FILL;
    end else
`endif
    if (a_hs_c) begin
      addr_d       = bus.a_addr;
      data_d       = bus.a_data;
      write_en_d   = 1'b1;
      last_grant_d = 1'b0;
    end else if (b_hs_c) begin
      addr_d       = bus.b_addr;
      data_d       = bus.b_data;
      write_en_d   = 1'b1;
      last_grant_d = 1'b1;
    end
`ifdef DISP_WRITE_FILL_EN
    busy_d = (state_d == FILL);
`endif
  end

  always_ff @(posedge clk_bram_disp or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      data_q       <= '0;
      write_en_q   <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      addr_q       <= addr_d;
      data_q       <= data_d;
      write_en_q   <= write_en_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_disp_write_arbiter.sv
// Randomized bench for disp_write_arbiter against a cycle-level reference model.
// Fill expectations follow DISP_WRITE_FILL_EN, matching the build of the design.
module tb_disp_write_arbiter;
  localparam int unsigned AW    = 13;
  localparam int unsigned DW    = 24;
  localparam int unsigned DEPTH = 8192;
`ifdef DISP_WRITE_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          fill_start;
  logic [DW-1:0] fill_color;
  logic          fill_busy, fill_done, last_grant;

  always #5 clk = ~clk;

  disp_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  disp_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk_bram_disp (clk),
    .rst           (rst),
    .bus           (bus),
    .fill_start    (fill_start),
    .fill_color    (fill_color),
    .fill_busy     (fill_busy),
    .fill_done     (fill_done),
    .last_grant    (last_grant)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: fill is "writes still owed" plus next address; arbitration from the tie rule
  bit            m_last;
  int            m_left, m_faddr, n_done;
  logic [DW-1:0] m_color;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  bit            e_we, e_busy, e_done, ra, rb, a_pend, b_pend;

  task automatic model_reset();
    m_last = 1'b1; m_left = 0; m_faddr = 0; m_color = '0;
    e_addr = '0; e_data = '0; e_we = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    a_pend = 1'b0; b_pend = 1'b0;
  endtask

  task automatic check_outputs();
    check_eq("write_en",   32'(bus.write_en), 32'(e_we));
    check_eq("addr",       32'(bus.addr),     32'(e_addr));
    check_eq("data",       32'(bus.data),     32'(e_data));
    check_eq("fill_busy",  32'(fill_busy),    32'(e_busy));
    check_eq("fill_done",  32'(fill_done),    32'(e_done));
    check_eq("last_grant", 32'(last_grant),   32'(m_last));
  endtask

  // Inputs are set at the falling edge before this is called
  task automatic tick();
    bit fs_eff;
    #1;
    fs_eff = FILL_EN && fill_start && (m_left == 0);
    if (m_left > 0 || (FILL_EN && fill_start)) begin
      ra = 1'b0; rb = 1'b0;
    end else begin
      ra = bus.a_valid && (!bus.b_valid || m_last);
      rb = bus.b_valid && !ra;
    end
    check_eq("a_ready", 32'(bus.a_ready), 32'(ra));
    check_eq("b_ready", 32'(bus.b_ready), 32'(rb));
    @(posedge clk);
    e_done = 1'b0;
    if (m_left > 0) begin
      e_we = 1'b1; e_addr = AW'(m_faddr); e_data = m_color;
      m_faddr++; m_left--;
      e_done = (m_left == 0);
    end else if (fs_eff) begin
      m_color = fill_color;
      e_we = 1'b1; e_addr = '0; e_data = fill_color;
      m_faddr = 1; m_left = DEPTH - 1;
    end else if (ra) begin
      e_we = 1'b1; e_addr = bus.a_addr; e_data = bus.a_data; m_last = 1'b0;
    end else if (rb) begin
      e_we = 1'b1; e_addr = bus.b_addr; e_data = bus.b_data; m_last = 1'b1;
    end else begin
      e_we = 1'b0;
    end
    e_busy = (m_left > 0);
    a_pend = bus.a_valid && !ra;
    b_pend = bus.b_valid && !rb;
    #1;
    check_outputs();
    if (fill_done) n_done++;
    @(negedge clk);
  endtask

  // New random request only where the previous one has been accepted
  task automatic drive(input int pa, input int pb);
    if (!a_pend) begin
      bus.a_valid = ($urandom_range(99) < 32'(pa));
      bus.a_addr  = AW'($urandom);
      bus.a_data  = DW'($urandom);
    end
    if (!b_pend) begin
      bus.b_valid = ($urandom_range(99) < 32'(pb));
      bus.b_addr  = AW'($urandom);
      bus.b_data  = DW'($urandom);
    end
  endtask

  task automatic start_fill(input logic [DW-1:0] c);
    fill_start = 1'b1;
    fill_color = c;
    tick();
    fill_start = 1'b0;
    fill_color = DW'($urandom);
  endtask

  initial begin
    int d0;
    rst = 1'b1; fill_start = 1'b0; fill_color = '0; n_done = 0;
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // A alone
    bus.a_valid = 1'b1; bus.a_addr = 13'h0010; bus.a_data = 24'hFF0000;
    tick();
    check_eq("t1_addr", 32'(bus.addr), 32'h10);
    check_eq("t1_data", 32'(bus.data), 32'hFF0000);
    check_eq("t1_last", 32'(last_grant), 32'h0);
    bus.a_valid = 1'b0;

    // B alone, so the contention below starts with A
    bus.b_valid = 1'b1; bus.b_addr = 13'h1234; bus.b_data = 24'h00ABCD;
    tick();
    bus.b_valid = 1'b0;

    // Contention: A,B,A,B back to back
    for (int i = 0; i < 4; i++) begin
      drive(100, 100);
      tick();
      check_eq("rr_alt", 32'(last_grant), 32'(i % 2));
      check_eq("rr_we",  32'(bus.write_en), 32'h1);
    end
    for (int i = 0; i < 3; i++) begin drive(0, 0); tick(); end

    // Fill with A held valid across it
    bus.a_valid = 1'b1; bus.a_addr = 13'h0055; bus.a_data = 24'h123456;
    d0 = n_done;
    start_fill(24'h00FF00);
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin drive(100, 0); tick(); end
    check_eq("fill1_done_cnt", 32'(n_done - d0), FILL_EN ? 32'd1 : 32'd0);
    for (int i = 0; i < 3; i++) begin drive(0, 0); tick(); end

    // Second fill_start mid-fill must be ignored
    d0 = n_done;
    start_fill(24'hA5A5A5);
    for (int i = 0; i < 50; i++) begin drive(30, 30); tick(); end
    start_fill(24'h0000FF);
    for (int i = 0; i < int'(DEPTH); i++) begin drive(30, 30); tick(); end
    check_eq("fill2_done_cnt", 32'(n_done - d0), FILL_EN ? 32'd1 : 32'd0);

    // Reset while the fill is at address 100
    start_fill(24'h777777);
    for (int i = 0; i < 200 && !(FILL_EN && m_faddr == 101); i++) begin drive(50, 50); tick(); end
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    check_eq("rst_a_ready", 32'(bus.a_ready), 32'(bus.a_valid));
    @(negedge clk);
    rst = 1'b0;
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    start_fill(24'h0F0F0F);
    check_eq("refill_addr", 32'(bus.addr), 32'h0);
    for (int i = 0; i < 20; i++) begin drive(50, 50); tick(); end

    // Random traffic
    for (int i = 0; i < 500; i++) begin drive(60, 60); tick(); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/disp_write_arbiter.md
# disp_write_arbiter

Sole owner of the display BRAM write port (`addr`/`data`/`write_en` into the 24-bit × 8192 display buffer on `clk_bram_disp`). It arbitrates round-robin between two valid/ready pixel-write requesters and registers the winning write onto the port. Requester A is the life engine and requester B is the host/debug path. An optional built-in fill sequencer can clear or paint the whole frame buffer with one colour, and it holds off both requesters while it runs.

## Interface
- `ADDR_W`, 13: BRAM address width.
- `DATA_W`, 24: pixel width (8R/8G/8B).
- `DEPTH`, 8192: words swept by a fill (128×64); must be ≤ 2^ADDR_W.

Ports:
- `clk_bram_disp` in 1: single clock, same as the BRAM write port.
- `rst` in 1: reset, asynchronous and active-high.
- `a_valid` in 1, `a_ready` out 1, `a_addr` in ADDR_W, `a_data` in DATA_W: requester A.
- `b_valid` in 1, `b_ready` out 1, `b_addr` in ADDR_W, `b_data` in DATA_W: requester B.
- `fill_start` in 1: one-cycle request to fill the whole buffer.
- `fill_color` in DATA_W: fill colour, sampled together with `fill_start`.
- `fill_busy` out 1: fill in progress.
- `fill_done` out 1: one-cycle pulse at completion.
- `addr` out ADDR_W, `data` out DATA_W, `write_en` out 1: registered BRAM write port.
- `last_grant` out 1: 0 means A was granted last, 1 means B.

## Operation
- States: `IDLE`, `FILL`.
- In `IDLE`, `a_ready`/`b_ready` are combinational.
  - Only one may be high in a cycle.
  - Both are forced 0 when `fill_start`=1, since fill has priority.
- Arbitration in `IDLE`:
  - Only one requester valid: that requester is granted.
  - Both valid: the one not equal to `last_grant` is granted. `last_grant` updates on every handshake.
  - Neither valid: nothing is granted and `write_en` is 0 next cycle.
- Handshake is `valid & ready`. The next clock edge registers that requester's addr/data to `addr`/`data` with `write_en`=1.
- Requesters must hold addr/data stable while `valid`=1 and `ready`=0.
- `fill_start`=1 in `IDLE`:
  - Latch `fill_color`.
  - Register `addr`=0, `data`=colour, `write_en`=1.
  - Load internal counter with 1 and move to `FILL`.
- In `FILL`:
  - Each edge registers `addr`=counter, `data`=latched colour, `write_en`=1, then increments the counter.
  - When the counter reaches DEPTH−1, that last write is registered, `fill_done`<=1, and the state returns to `IDLE`.
  - `fill_start` is ignored while in `FILL`.
  - Both readies are 0 throughout `FILL`.
- `fill_busy` is the registered flag (state==`FILL`).
- Counter width is ADDR_W+1 internally; addresses never wrap past DEPTH−1.
- Reset, async at any time including mid-fill: state=`IDLE`, `write_en`=0, `addr`=0, `data`=0, `fill_busy`=0, `fill_done`=0, `last_grant`=1 (so A wins the first contention), counter=0.
  - A fill interrupted by reset is abandoned and not resumed.

## Timing
- Handshake to BRAM write: 1 cycle (registered output). Throughput is 1 write/cycle in `IDLE` under continuous requests.
- Fill sampled at edge T:
  - Writes to addresses 0..DEPTH−1 appear in cycles T+1..T+DEPTH.
  - `fill_busy`=1 in cycles T+1..T+DEPTH−1.
  - `fill_done`=1 only in cycle T+DEPTH, coincident with the write to DEPTH−1.
- Cycle T+DEPTH is `IDLE`, so a request may handshake there and its write appears at T+DEPTH+1. There is no gap and no overlap.
- `fill_start` and a valid request in the same `IDLE` cycle: fill wins, and the request waits until the fill ends.
- Simultaneous reset and any input: reset wins.

## Configuration
- `DISP_WRITE_FILL_EN`
  - Defined: fill sequencer, `FILL` state, colour latch and counter are present, with the behaviour above.
  - Undefined: `fill_start`/`fill_color` are ignored, `fill_busy`=`fill_done`=0 constantly, and the block is a pure two-requester round-robin arbiter with no fill priority masking on readies.

## Test plan
- Reset, then A-only request `a_addr`=0x0010, `a_data`=0xFF0000: `a_ready`=1 the same cycle; next cycle `write_en`=1, `addr`=0x0010, `data`=0xFF0000; `last_grant`=0.
- A and B both valid for 4 cycles: grants alternate A,B,A,B. Outputs carry the matching addr/data with one-cycle latency and `write_en`=1 for 4 consecutive cycles.
- `fill_start` with `fill_color`=0x00FF00 at T, with A held valid:
  - Writes 0..8191 appear at T+1..T+8192, all with data 0x00FF00.
  - `fill_done` pulses only at T+8192.
  - A is granted at T+8192 and its write appears at T+8193.
- Second `fill_start` pulsed mid-fill: ignored, so exactly 8192 writes occur and one `fill_done`.
- Reset asserted at fill address 100: all outputs return to their reset values immediately. After release, a new fill starts again from address 0.
- Build without `DISP_WRITE_FILL_EN`, pulse `fill_start`: no writes occur, `fill_busy`/`fill_done` stay 0, and A/B arbitration is unchanged.
